// File: rtl/aclint_multi_hart.sv
// ACLINT for NUM_HARTS harts: shared prescaled mtime, per-hart MTIMECMP,
// MSIP and SETSSIP, on a 64-bit request/response bus with one-cycle responses.
module aclint_multi_hart #(
  parameter int NUM_HARTS      = 2,
  parameter int MTIME_PRESCALE = 1,
  parameter int ADDR_WIDTH     = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  bus_valid,
  output logic                  bus_ready,
  input  logic [ADDR_WIDTH-1:0] bus_addr,
  input  logic                  bus_wen,
  input  logic [63:0]           bus_wdata,
  input  logic [7:0]            bus_wmask,
  output logic                  bus_rvalid,
  output logic [63:0]           bus_rdata,
  output logic [63:0]           mtime_o,
  output logic [NUM_HARTS-1:0]  msip,
  output logic [NUM_HARTS-1:0]  mtip,
  output logic [NUM_HARTS-1:0]  ssip_set
);

  localparam int PW = (MTIME_PRESCALE > 1) ? $clog2(MTIME_PRESCALE) : 1;

  logic [PW-1:0]                pcnt;
  logic                         tick;
  logic [63:0]                  mtime;
  logic [NUM_HARTS-1:0][63:0]   mtimecmp;

  logic [15:0]                  off;
  logic [10:0]                  sub;
  logic                         unused_low;
  logic                         sel_msip, sel_cmp, sel_mtime, sel_ssip;
  logic                         acc_w;
  logic                         wr_mtime;
  logic [NUM_HARTS-1:0]         wr_cmp, wr_msip, msip_d, set_ssip;
  logic [63:0]                  rd_next;

  logic                         rvalid_q;
  logic [63:0]                  rdata_q;

  // Only bytes whose mask bit is set take the new value.
  function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] wd,
                                        input logic [7:0] m);
    logic [63:0] r;
    for (int b = 0; b < 8; b++) r[8*b +: 8] = m[b] ? wd[8*b +: 8] : old[8*b +: 8];
    return r;
  endfunction

  // Address decode: the window is split into 16 KB regions; sub indexes the
  // doubleword within a region (hart for MTIMECMP, hart pair for MSIP/SETSSIP).
  assign off        = 16'(bus_addr);
  assign sub        = off[13:3];
  assign unused_low = ^off[2:0];
  assign sel_mtime  = (off[15:3] == 13'h0FFF);
  assign sel_msip   = (off[15:14] == 2'b00);
  assign sel_cmp    = (off[15:14] == 2'b01) && !sel_mtime;
  assign sel_ssip   = (off[15:14] == 2'b10);
  assign acc_w      = bus_valid && bus_wen;
  assign wr_mtime   = acc_w && sel_mtime;
  assign tick       = (pcnt == PW'(MTIME_PRESCALE - 1));

  assign bus_ready  = 1'b1;
  assign mtime_o    = mtime;
  // A response pending while reset is asserted is suppressed.
  assign bus_rvalid = rvalid_q & ~rst;
  assign bus_rdata  = rst ? 64'd0 : rdata_q;

  // Per-hart write strobes; odd harts of a pair live in the upper word.
  always_comb begin
    wr_cmp   = '0;
    wr_msip  = '0;
    msip_d   = '0;
    set_ssip = '0;
    for (int h = 0; h < NUM_HARTS; h++) begin
      wr_cmp[h]   = acc_w && sel_cmp && (h == int'(sub));
      wr_msip[h]  = acc_w && sel_msip && (h / 2 == int'(sub)) && bus_wmask[4*(h%2)];
      msip_d[h]   = bus_wdata[32*(h%2)];
      set_ssip[h] = acc_w && sel_ssip && (h / 2 == int'(sub)) && bus_wmask[4*(h%2)]
                    && bus_wdata[32*(h%2)];
    end
  end

  // Read mux from pre-write state; writes, SETSSIP and holes return 0.
  always_comb begin
    rd_next = '0;
    if (!bus_wen) begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (sel_msip && (h == 2 * int'(sub)))     rd_next[0]  = msip[h];
        if (sel_msip && (h == 2 * int'(sub) + 1)) rd_next[32] = msip[h];
        if (sel_cmp && (h == int'(sub)))          rd_next     = mtimecmp[h];
      end
      if (sel_mtime) rd_next = mtime;
    end
  end

  // Prescaler and mtime; a bus write beats a coincident increment.
  always_ff @(posedge clk) begin
    if (rst) begin
      pcnt  <= '0;
      mtime <= '0;
    end else begin
      pcnt <= tick ? '0 : pcnt + PW'(1);
      if (wr_mtime)  mtime <= merge(mtime, bus_wdata, bus_wmask);
      else if (tick) mtime <= mtime + 64'd1;
    end
  end

  // Per-hart compare registers, software interrupt bits and timer compare.
  always_ff @(posedge clk) begin
    if (rst) begin
      mtimecmp <= '1;
      msip     <= '0;
      mtip     <= '0;
      ssip_set <= '0;
    end else begin
      for (int h = 0; h < NUM_HARTS; h++) begin
        if (wr_cmp[h])  mtimecmp[h] <= merge(mtimecmp[h], bus_wdata, bus_wmask);
        if (wr_msip[h]) msip[h]     <= msip_d[h];
        mtip[h] <= (mtime >= mtimecmp[h]);
      end
      ssip_set <= set_ssip;
    end
  end

  // One response per accepted request, one cycle later.
  always_ff @(posedge clk) begin
    if (rst) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= bus_valid;
      rdata_q  <= bus_valid ? rd_next : 64'd0;
    end
  end

endmodule

// File: tb/tb_aclint_multi_hart.sv
// Scoreboard bench: two instances (prescale 1 and 4) share one bus; each
// request pushes the expected read data, a negedge monitor pops on rvalid.
module tb_aclint_multi_hart;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        bus_valid = 1'b0;
  logic        bus_wen = 1'b0;
  logic [15:0] bus_addr = '0;
  logic [63:0] bus_wdata = '0;
  logic [7:0]  bus_wmask = '0;

  logic        rdy1, rv1, rdy4, rv4;
  logic [63:0] rd1, mt1, rd4, mt4;
  logic [1:0]  msip1, mtip1, ssip1, msip4, mtip4, ssip4;

  localparam logic [63:0] ALL1 = 64'hFFFF_FFFF_FFFF_FFFF;

  always #5 clk = ~clk;

  aclint_multi_hart #(.NUM_HARTS(2), .MTIME_PRESCALE(1), .ADDR_WIDTH(16)) u1 (
    .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_ready(rdy1), .bus_addr(bus_addr),
    .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_rvalid(rv1),
    .bus_rdata(rd1), .mtime_o(mt1), .msip(msip1), .mtip(mtip1), .ssip_set(ssip1));

  aclint_multi_hart #(.NUM_HARTS(2), .MTIME_PRESCALE(4), .ADDR_WIDTH(16)) u4 (
    .clk(clk), .rst(rst), .bus_valid(bus_valid), .bus_ready(rdy4), .bus_addr(bus_addr),
    .bus_wen(bus_wen), .bus_wdata(bus_wdata), .bus_wmask(bus_wmask), .bus_rvalid(rv4),
    .bus_rdata(rd4), .mtime_o(mt4), .msip(msip4), .mtip(mtip4), .ssip_set(ssip4));

  typedef struct {
    string       name;
    logic [63:0] e1;
    logic [63:0] e4;
  } exp_t;

  exp_t   exp_q[$];
  exp_t   mon_e;
  int     total = 0;
  int     bad = 0;
  longint ncyc = 0;

  // Clock edges since reset release: equals mtime of the prescale-1 instance.
  always @(posedge clk) begin
    if (rst) ncyc <= 0;
    else     ncyc <= ncyc + 1;
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", nm, act, exp);
    end
  endtask

  // Monitor: every response must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rv1 || rv4) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL rvalid_unexpected got rv1=%0b rv4=%0b exp none", rv1, rv4);
      end else begin
        mon_e = exp_q.pop_front();
        chk({mon_e.name, "_rvalid"}, {62'd0, rv4, rv1}, 64'd3);
        chk({mon_e.name, "_p1"}, rd1, mon_e.e1);
        chk({mon_e.name, "_p4"}, rd4, mon_e.e4);
      end
    end
  end

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input string nm, input logic w, input logic [15:0] a,
                     input logic [63:0] wd, input logic [7:0] wm,
                     input logic [63:0] e1, input logic [63:0] e4);
    exp_t e;
    e.name = nm; e.e1 = e1; e.e4 = e4;
    bus_valid = 1'b1; bus_wen = w; bus_addr = a; bus_wdata = wd; bus_wmask = wm;
    exp_q.push_back(e);
    @(posedge clk);
    #1;
    bus_valid = 1'b0; bus_wen = 1'b0; bus_wmask = '0;
  endtask

  task automatic wr(input string nm, input logic [15:0] a, input logic [63:0] wd,
                    input logic [7:0] wm);
    req(nm, 1'b1, a, wd, wm, 64'd0, 64'd0);
  endtask

  task automatic rd(input string nm, input logic [15:0] a, input logic [63:0] e1,
                    input logic [63:0] e4);
    req(nm, 1'b0, a, 64'd0, 8'h00, e1, e4);
  endtask

  task automatic chk_reset_state(input string pfx);
    chk({pfx, "_msip"},   {60'd0, msip4, msip1}, 64'd0);
    chk({pfx, "_mtip"},   {60'd0, mtip4, mtip1}, 64'd0);
    chk({pfx, "_ssip"},   {60'd0, ssip4, ssip1}, 64'd0);
    chk({pfx, "_rvalid"}, {62'd0, rv4, rv1}, 64'd0);
    chk({pfx, "_rdata"},  rd1 | rd4, 64'd0);
    chk({pfx, "_mtime"},  mt1 | mt4, 64'd0);
    chk({pfx, "_ready"},  {62'd0, rdy4, rdy1}, 64'd3);
  endtask

  initial begin
    int n;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("rst");

    // reset values over the bus; mtime tracks edges since release
    sync();
    rd("cmp0_rst", 16'h4000, ALL1, ALL1);
    rd("mtime_early", 16'h7FF8, 64'(ncyc), 64'(ncyc / 4));

    // timer interrupt on hart 1
    wr("cmp1_wr20", 16'h4008, 64'd20, 8'hFF);
    @(negedge clk);
    n = 0;
    while (mt1 != 64'd20 && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("mtime_reach20", mt1, 64'd20);
    chk("mtip_at20", {60'd0, mtip4, mtip1}, 64'd0);
    @(negedge clk);
    chk("mtip1_rise", {60'd0, mtip4, mtip1}, 64'h2);
    sync();
    rd("mtime_mid", 16'h7FF8, 64'(ncyc), 64'(ncyc / 4));
    wr("cmp1_wr1000", 16'h4008, 64'd1000, 8'hFF);
    @(negedge clk);
    chk("mtip1_hold", {62'd0, mtip1}, 64'h2);
    @(negedge clk);
    chk("mtip1_fall", {60'd0, mtip4, mtip1}, 64'd0);

    // msip packing and byte enables
    sync();
    wr("msip1_wr", 16'h0000, 64'h0000_0001_0000_0000, 8'hF0);
    @(negedge clk);
    chk("msip_set", {60'd0, msip4, msip1}, 64'hA);
    sync();
    rd("msip_rd", 16'h0000, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000);
    rd("ssip_rd", 16'h8000, 64'd0, 64'd0);
    wr("msip_nobyte", 16'h0000, 64'h0000_0001_0000_0001, 8'hEE);
    @(negedge clk);
    chk("msip_masked", {60'd0, msip4, msip1}, 64'hA);

    // setssip pulses
    sync();
    wr("ssip_wr", 16'h8000, 64'h0000_0001_0000_0001, 8'hFF);
    @(negedge clk);
    chk("ssip_pulse", {60'd0, ssip4, ssip1}, 64'hF);
    @(negedge clk);
    chk("ssip_clear", {60'd0, ssip4, ssip1}, 64'd0);
    sync();
    wr("ssip_zero", 16'h8000, 64'd0, 8'hFF);
    @(negedge clk);
    chk("ssip_zero_nop", {60'd0, ssip4, ssip1}, 64'd0);
    chk("msip_untouched", {60'd0, msip4, msip1}, 64'hA);

    // mtimecmp byte merge
    sync();
    wr("cmp0_merge", 16'h4000, 64'h1122_3344_5566_7788, 8'h0F);
    rd("cmp0_rd", 16'h4000, 64'hFFFF_FFFF_5566_7788, 64'hFFFF_FFFF_5566_7788);

    // harts beyond NUM_HARTS and holes
    wr("h3_cmp_wr", 16'h4018, 64'd0, 8'hFF);
    rd("h3_cmp_rd", 16'h4018, 64'd0, 64'd0);
    wr("h23_msip_wr", 16'h0008, 64'h0000_0001_0000_0001, 8'hFF);
    rd("h23_msip_rd", 16'h0008, 64'd0, 64'd0);
    rd("unmapped_rd", 16'hC000, 64'd0, 64'd0);
    @(negedge clk);
    chk("h3_no_alias_mtip", {60'd0, mtip4, mtip1}, 64'd0);
    chk("h23_no_alias_msip", {60'd0, msip4, msip1}, 64'hA);

    // mtime write coinciding with an increment of both instances, then wrap
    sync();
    n = 0;
    while (ncyc % 4 != 3 && n < 8) begin
      sync();
      n++;
    end
    wr("mtime_wr", 16'h7FF8, 64'hFFFF_FFFF_FFFF_FFFE, 8'hFF);
    rd("mtime_rd_after_wr", 16'h7FF8, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    chk("mtime_w1_p1", mt1, ALL1);
    chk("mtime_w1_p4", mt4, 64'hFFFF_FFFF_FFFF_FFFE);
    @(negedge clk);
    chk("mtime_wrap_p1", mt1, 64'd0);
    chk("mtime_w2_p4", mt4, 64'hFFFF_FFFF_FFFF_FFFE);
    repeat (2) @(negedge clk);
    chk("mtime_w4_p1", mt1, 64'd2);
    chk("mtime_w4_p4", mt4, ALL1);
    repeat (4) @(negedge clk);
    chk("mtime_w8_p1", mt1, 64'd6);
    chk("mtime_wrap_p4", mt4, 64'd0);

    // reset drops an outstanding response
    sync();
    bus_valid = 1'b1; bus_wen = 1'b0; bus_addr = 16'h4000;
    @(posedge clk);
    #1;
    bus_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_drop_rvalid", {62'd0, rv4, rv1}, 64'd0);
    sync();
    rst = 1'b0;
    @(negedge clk);
    chk_reset_state("rst2");
    sync();
    rd("cmp1_after_rst", 16'h4008, ALL1, ALL1);
    rd("mtime_after_rst", 16'h7FF8, 64'(ncyc), 64'(ncyc / 4));

    repeat (3) @(negedge clk);
    chk("pending_responses", 64'(exp_q.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aclint_multi_hart.md
Name: aclint_multi_hart

Overview:
- Parametrised ACLINT device: shared 64-bit mtime, plus per-hart MTIMECMP, MSIP and SETSSIP for NUM_HARTS harts.
- Attaches to the 64-bit memory bus at the 0x0200_0000 window; the decoder passes an offset-relative address.
- Drives msip/mtip levels and ssip set pulses to each core's interrupt logic.
- Exports mtime for the TIME CSR.

Parameters:
NUM_HARTS, 2, number of harts served (1..8).
MTIME_PRESCALE, 1, clk cycles per mtime increment (>=1).
ADDR_WIDTH, 16, width of the offset address (window 0x0000-0xBFFF).

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
bus_valid  in  1  request valid
bus_ready  out  1  request accepted; constant 1
bus_addr  in  ADDR_WIDTH  byte offset into window, 8-byte aligned (addr[2:0] ignored)
bus_wen  in  1  1=write, 0=read
bus_wdata  in  64  write data
bus_wmask  in  8  byte enables for writes
bus_rvalid  out  1  read/write response valid
bus_rdata  out  64  read data
mtime_o  out  64  current mtime
msip  out  NUM_HARTS  machine software interrupt level per hart
mtip  out  NUM_HARTS  machine timer interrupt level per hart
ssip_set  out  NUM_HARTS  one-cycle pulse: set mip.SSIP of hart h

Behaviour:
Interface:
- One clock, clk. Reset rst is synchronous and active-high.
- All state is updated on the clk rising edge.

Reset values:
- mtime=0, prescale counter=0, every mtimecmp=0xFFFF_FFFF_FFFF_FFFF, msip=0, mtip=0, ssip_set=0.
- bus_rvalid=0, bus_rdata=0.
- Reset mid-transaction drops the pending response: no rvalid is issued for it.

Address map (offsets):
- MSIP at 0x0000+4h: 32-bit word, bit0 only. Doubleword 8k carries hart 2k in bytes 0-3 and hart 2k+1 in bytes 4-7.
- MTIMECMP at 0x4000+8h: 64-bit.
- MTIME at 0x7FF8: 64-bit.
- SETSSIP at 0x8000+4h: 32-bit, same packing as MSIP.
- Harts with h>=NUM_HARTS and unmapped offsets read 0; writes to them are ignored.

Handshake:
- bus_ready is tied to 1, so every cycle with bus_valid=1 is one accepted request.
- bus_rvalid pulses exactly one cycle after each accepted request (reads and writes), so back-to-back requests produce back-to-back responses.
- bus_rdata is registered in the acceptance cycle from pre-write register state.
- bus_rdata is 0 for writes and for SETSSIP reads.

Writes:
- Byte-merge: only bytes with bus_wmask=1 change.
- MSIP and SETSSIP use bit0 of their word; a word is written only when its byte 0 (or byte 4) is enabled.
- SETSSIP write with bit0=1 produces ssip_set[h]=1 for the following cycle only. A write with bit0=0 has no effect.

mtime:
- Prescale counter runs 0..MTIME_PRESCALE-1. mtime increments by 1 in the cycle the counter is at MTIME_PRESCALE-1, and the counter wraps to 0.
- mtime wraps from 0xFFFF_FFFF_FFFF_FFFF to 0.
- A bus write to MTIME in the same cycle as an increment: the write wins (merged bytes from the pre-increment value, no increment that cycle); the prescale counter keeps running.
- mtime_o shows the register value.

mtip:
- mtip[h] is registered: mtip[h] <= (mtime >= mtimecmp[h]), unsigned compare of current register values. Latency is 1 cycle after the register change.
- A MTIMECMP write that raises the compare value clears mtip the cycle after the write takes effect.

msip:
- msip[h] is the register bit directly, visible the cycle after the write.

Test Plan:
- Reset, then read MTIMECMP0 (0x4000) and MTIME with PRESCALE=1 -> 0xFFFF_FFFF_FFFF_FFFF; mtime equals the cycle count since reset, mtip=0, msip=0.
- Write MTIMECMP1 (0x4008)=20, mask 0xFF; run until mtime=20 -> mtip[1] rises the cycle after mtime reaches 20, mtip[0] stays 0. Write MTIMECMP1=1000 -> mtip[1] falls after 1 cycle.
- Write 0x0000 with wdata=0x0000_0001_0000_0000, mask 0xF0 -> msip=2'b10. Read 0x0000 -> 0x0000_0001_0000_0000. Read SETSSIP 0x8000 -> 0.
- Write 0x8000 with wdata=0x1_0000_0001, mask 0xFF -> ssip_set=2'b11 for exactly one cycle, then 0.
- Write MTIME=0xFFFF_FFFF_FFFF_FFFE in the same cycle as an increment -> mtime reads 0xFFFF_FFFF_FFFF_FFFE, then wraps to 0 two increments later. With MTIME_PRESCALE=4, increments occur every 4 cycles.
- Issue a read of 0x4000 and assert rst in the next cycle -> no bus_rvalid. Afterwards all outputs hold reset values; an access to hart index 3 (NUM_HARTS=2) reads 0 and its writes are ignored.
